// File: rtl/player_ship.sv
// ---------------------------------------------------------------------------
// player_ship
// Player ship controller: keyboard-driven horizontal movement, edge-detected
// fire with cooldown, hit/explode/respawn/game-over life cycle.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module player_ship #(
  parameter int SCREEN_W       = 640,
  parameter int SHIP_W         = 26,
  parameter int STEP           = 2,
  parameter int NUM_KEYS       = 2,
  parameter int COOLDOWN       = 30,
  parameter int EXPLODE_FRAMES = 60,
  parameter int INVULN_FRAMES  = 120,
  parameter int START_LIVES    = 3
) (
  input  logic                  frame_clk,
  input  logic                  Reset,
  input  logic [8*NUM_KEYS-1:0] keycode,
  input  logic                  bullet_active,
  input  logic                  hit,
  output logic [9:0]            ship_x,
  output logic [9:0]            ship_w,
  output logic                  fire,
  output logic [1:0]            lives,
  output logic                  visible,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    EXPLODE   = 2'd1,
    RESPAWN   = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam int CD_W  = $clog2(COOLDOWN + 1);
  localparam int EX_W  = $clog2(EXPLODE_FRAMES + 1);
  // Blink uses bit 3 of the invulnerability counter, so keep at least 4 bits.
  localparam int INV_W = ($clog2(INVULN_FRAMES + 1) > 4) ? $clog2(INVULN_FRAMES + 1) : 4;

  localparam logic signed [10:0] MAX_X    = 11'(SCREEN_W - SHIP_W);
  localparam logic signed [10:0] STEP_S   = 11'(STEP);
  localparam logic [9:0]         CENTER_X = 10'((SCREEN_W - SHIP_W) / 2);

  state_t            state_q, state_d;
  logic [9:0]        x_q, x_d;
  logic [1:0]        lives_q, lives_d;
  logic              fire_q, fire_d;
  logic              fire_prev_q, fire_prev_d;
  logic [CD_W-1:0]   cd_q, cd_d;
  logic [EX_W-1:0]   ex_q, ex_d;
  logic [INV_W-1:0]  inv_q, inv_d;

  logic              key_left, key_right, key_fire;
  logic              movable, fire_ok;
  logic signed [10:0] pos_cur, pos_nxt;

  // Key decode: a key is pressed if it appears on any channel.
  always_comb begin
    key_left  = 1'b0;
    key_right = 1'b0;
    key_fire  = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keycode[8*i +: 8] == 8'h04) key_left  = 1'b1;
      if (keycode[8*i +: 8] == 8'h07) key_right = 1'b1;
      if (keycode[8*i +: 8] == 8'h2C) key_fire  = 1'b1;
    end
  end

  // Next-state logic: movement, fire gating and the life-cycle FSM.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    lives_d     = lives_q;
    fire_d      = 1'b0;
    fire_prev_d = key_fire;
    cd_d        = (cd_q == '0) ? '0 : cd_q - 1'b1;
    ex_d        = ex_q;
    inv_d       = inv_q;

    movable = (state_q == ALIVE) || (state_q == RESPAWN);
    fire_ok = movable && key_fire && !fire_prev_q && (cd_q == '0) && !bullet_active;

    // Signed 11-bit arithmetic so stepping past either edge clamps instead of wrapping.
    pos_cur = signed'({1'b0, x_q});
    pos_nxt = pos_cur;
    if (movable && key_left && !key_right) begin
      pos_nxt = pos_cur - STEP_S;
      if (pos_nxt < 0) pos_nxt = '0;
    end else if (movable && key_right && !key_left) begin
      pos_nxt = pos_cur + STEP_S;
      if (pos_nxt > MAX_X) pos_nxt = MAX_X;
    end
    x_d = pos_nxt[9:0];

    // A hit in ALIVE takes priority over a simultaneous shot.
    if (fire_ok && !(state_q == ALIVE && hit)) begin
      fire_d = 1'b1;
      cd_d   = CD_W'(COOLDOWN - 1);
    end

    case (state_q)
      ALIVE: begin
        if (hit) begin
          state_d = EXPLODE;
          lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
          ex_d    = EX_W'(EXPLODE_FRAMES - 1);
        end
      end
      EXPLODE: begin
        if (ex_q == '0) begin
          if (lives_q == 2'd0) begin
            state_d = GAME_OVER;
          end else begin
            state_d = RESPAWN;
            x_d     = CENTER_X;
            inv_d   = INV_W'(INVULN_FRAMES - 1);
          end
        end else begin
          ex_d = ex_q - 1'b1;
        end
      end
      RESPAWN: begin
        if (inv_q == '0) state_d = ALIVE;
        else             inv_d   = inv_q - 1'b1;
      end
      default: ;  // GAME_OVER holds everything until Reset
    endcase
  end

  // State register with asynchronous reset.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ALIVE;
      x_q         <= CENTER_X;
      lives_q     <= 2'(START_LIVES);
      fire_q      <= 1'b0;
      fire_prev_q <= 1'b0;
      cd_q        <= '0;
      ex_q        <= '0;
      inv_q       <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      lives_q     <= lives_d;
      fire_q      <= fire_d;
      fire_prev_q <= fire_prev_d;
      cd_q        <= cd_d;
      ex_q        <= ex_d;
      inv_q       <= inv_d;
    end
  end

  // Output decode; visibility blinks off the invulnerability counter while respawning.
  always_comb begin
    ship_x = x_q;
    ship_w = 10'(SHIP_W);
    fire   = fire_q;
    lives  = lives_q;
    state  = state_q;
    case (state_q)
      ALIVE:   visible = 1'b1;
      RESPAWN: visible = inv_q[3];
      default: visible = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_player_ship.sv
// ---------------------------------------------------------------------------
// tb_player_ship
// Directed, table-driven bench for player_ship at default parameters.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_player_ship;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [15:0] keycode;
  logic        bullet_active;
  logic        hit;
  logic [9:0]  ship_x;
  logic [9:0]  ship_w;
  logic        fire;
  logic [1:0]  lives;
  logic        visible;
  logic [1:0]  state;

  int n_chk  = 0;
  int n_fail = 0;

  player_ship dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .bullet_active (bullet_active),
    .hit           (hit),
    .ship_x        (ship_x),
    .ship_w        (ship_w),
    .fire          (fire),
    .lives         (lives),
    .visible       (visible),
    .state         (state)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [15:0] key;
    logic        bul;
    logic        hit;
    int          x;
    logic        fire;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    keycode       = 16'h0000;
    bullet_active = 1'b0;
    hit           = 1'b0;
    Reset         = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic chk_home(input string name);
    chk({name, "_x"},     int'(ship_x),  307);
    chk({name, "_state"}, int'(state),   0);
    chk({name, "_lives"}, int'(lives),   3);
    chk({name, "_fire"},  int'(fire),    0);
    chk({name, "_vis"},   int'(visible), 1);
  endtask

  initial begin
    int exp_x;
    int pulses;
    int inv;

    // Vectors applied in order right after reset; each row is one frame.
    vecs[0] = '{16'h0000, 1'b0, 1'b0, 307, 1'b0};  // idle
    vecs[1] = '{16'h0004, 1'b0, 1'b0, 305, 1'b0};  // left ch0
    vecs[2] = '{16'h0700, 1'b0, 1'b0, 307, 1'b0};  // right ch1
    vecs[3] = '{16'h0407, 1'b0, 1'b0, 307, 1'b0};  // right ch0 + left ch1
    vecs[4] = '{16'h002C, 1'b0, 1'b0, 307, 1'b1};  // fresh fire press
    vecs[5] = '{16'h2C04, 1'b0, 1'b0, 305, 1'b0};  // fire held + left
    vecs[6] = '{16'h0000, 1'b0, 1'b0, 305, 1'b0};  // release
    vecs[7] = '{16'h2C00, 1'b0, 1'b0, 305, 1'b0};  // re-press inside cooldown

    do_reset();
    chk_home("reset");
    chk("ship_w", int'(ship_w), 26);

    for (int i = 0; i < 8; i++) begin
      keycode       = vecs[i].key;
      bullet_active = vecs[i].bul;
      hit           = vecs[i].hit;
      tick();
      chk($sformatf("vec%0d_x", i),    int'(ship_x), vecs[i].x);
      chk($sformatf("vec%0d_fire", i), int'(fire),   int'(vecs[i].fire));
      chk($sformatf("vec%0d_state", i), int'(state), 0);
    end

    // Left held for 200 frames: 305, 303, ..., 1, then clamps at 0.
    do_reset();
    keycode = 16'h0004;
    exp_x = 307;
    for (int k = 0; k < 200; k++) begin
      exp_x = (exp_x - 2 < 0) ? 0 : exp_x - 2;
      tick();
      chk("left_sweep", int'(ship_x), exp_x);
    end

    // Right alone for 200 frames clamps at 614.
    do_reset();
    keycode = 16'h0007;
    exp_x = 307;
    for (int k = 0; k < 200; k++) begin
      exp_x = (exp_x + 2 > 614) ? 614 : exp_x + 2;
      tick();
      chk("right_sweep", int'(ship_x), exp_x);
    end

    // Fire held for 40 frames from frame 5 produces exactly one pulse.
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    keycode = 16'h002C;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (fire) pulses++;
    end
    chk("held_fire_pulses", pulses, 1);

    // Cooldown: pulse at frame 0, re-press at 20 blocked, re-press at 31 fires.
    do_reset();
    for (int k = 0; k <= 31; k++) begin
      keycode = (k == 0 || k == 20 || k == 31) ? 16'h002C : 16'h0000;
      tick();
      chk($sformatf("cooldown_f%0d", k), int'(fire), (k == 0 || k == 31) ? 1 : 0);
    end
    keycode = 16'h0000;
    for (int k = 0; k < 35; k++) tick();
    keycode = 16'h002C; bullet_active = 1'b1;
    tick();
    chk("fire_bullet_busy", int'(fire), 0);
    keycode = 16'h0000; bullet_active = 1'b0;
    tick();
    keycode = 16'h002C;
    tick();
    chk("fire_bullet_free", int'(fire), 1);

    // Hit with a simultaneous fresh fire press: hit wins.
    do_reset();
    keycode = 16'h002C; hit = 1'b1;
    tick();
    keycode = 16'h0000; hit = 1'b0;
    chk("hit_fire", int'(fire), 0);
    chk("hit_state", int'(state), 1);
    chk("hit_lives", int'(lives), 2);
    chk("hit_vis", int'(visible), 0);
    for (int k = 1; k < 60; k++) begin
      tick();
      chk("explode_state", int'(state), 1);
      chk("explode_vis", int'(visible), 0);
    end
    for (int k = 60; k < 180; k++) begin
      if (k == 100) hit = 1'b1;
      tick();
      hit = 1'b0;
      inv = 119 - (k - 60);
      chk("respawn_state", int'(state), 2);
      chk("respawn_vis", int'(visible), (inv >> 3) & 1);
      chk("respawn_lives", int'(lives), 2);
      if (k == 60) chk("respawn_x", int'(ship_x), 307);
    end
    tick();
    chk("back_alive", int'(state), 0);
    chk("back_alive_vis", int'(visible), 1);

    // Three hits lead to GAME_OVER, which ignores everything until Reset.
    do_reset();
    for (int h = 0; h < 3; h++) begin
      hit = 1'b1;
      tick();
      hit = 1'b0;
      chk($sformatf("hit%0d_lives", h), int'(lives), 2 - h);
      for (int k = 1; k < ((h == 2) ? 61 : 181); k++) tick();
      chk($sformatf("after_hit%0d_state", h), int'(state), (h == 2) ? 3 : 0);
    end
    chk("gameover_vis", int'(visible), 0);
    for (int k = 0; k < 10; k++) begin
      keycode = (k % 2 == 0) ? 16'h2C04 : 16'h0007;
      hit = 1'b1;
      tick();
      chk("gameover_state", int'(state), 3);
      chk("gameover_x", int'(ship_x), 307);
      chk("gameover_fire", int'(fire), 0);
      chk("gameover_lives", int'(lives), 0);
    end
    do_reset();
    chk_home("after_gameover");

    // Asynchronous reset mid-EXPLODE takes effect before the next edge.
    do_reset();
    hit = 1'b1;
    tick();
    hit = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    #2;
    Reset = 1'b1;
    #1;
    chk_home("async_explode");
    tick();
    Reset = 1'b0;

    // Asynchronous reset mid-RESPAWN with a fire press pending.
    hit = 1'b1;
    tick();
    hit = 1'b0;
    for (int k = 0; k < 70; k++) tick();
    chk("pre_rst_respawn", int'(state), 2);
    keycode = 16'h002C;
    #2;
    Reset = 1'b1;
    #1;
    chk_home("async_respawn");
    keycode = 16'h0000;
    tick();
    Reset = 1'b0;
    tick();
    chk_home("post_async");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/player_ship.md
PLAYER_SHIP -- requirements
Module: player_ship

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning), one per line:
- SCREEN_W, 640, playfield width in pixels
- SHIP_W, 26, ship width in pixels
- STEP, 2, pixels moved per frame
- NUM_KEYS, 2, simultaneous keycode channels
- COOLDOWN, 30, frames between shots
- EXPLODE_FRAMES, 60, explosion duration
- INVULN_FRAMES, 120, post-respawn invulnerability
- START_LIVES, 3, lives at reset
REQ-002 The block SHALL expose these ports (name, direction, width, meaning), one per line:
- frame_clk, in, 1, frame clock (one edge per video frame)
- Reset, in, 1, asynchronous, active-high reset
- keycode, in, 8*NUM_KEYS, packed keycodes, channel i at bits [8i+7:8i]
- bullet_active, in, 1, player bullet currently in flight
- hit, in, 1, enemy projectile struck ship this frame
- ship_x, out, 10, ship left-edge X
- ship_w, out, 10, constant SHIP_W
- fire, out, 1, one-frame pulse requesting bullet spawn
- lives, out, 2, remaining lives
- visible, out, 1, draw enable (blinks while invulnerable)
- state, out, 2, FSM state encoding
REQ-003 Reset SHALL be asynchronous and active-high; all state SHALL change only on posedge frame_clk.

Function
REQ-004 Key decode SHALL scan all NUM_KEYS channels: left=8'h04, right=8'h07, fire=8'h2C; a key counts as pressed if it appears on any channel.
REQ-005 FSM states SHALL be ALIVE=0, EXPLODE=1, RESPAWN=2, GAME_OVER=3.
REQ-006 In ALIVE or RESPAWN, left only SHALL set ship_x to ship_x-STEP, saturating at 0.
REQ-007 In ALIVE or RESPAWN, right only SHALL set ship_x to ship_x+STEP, saturating at SCREEN_W-SHIP_W.
REQ-008 Left and right pressed together, or neither, SHALL leave ship_x unchanged.
REQ-009 Position arithmetic SHALL be 11-bit signed internally so that no wrap-around occurs at either edge.
REQ-010 fire SHALL pulse for exactly one frame when all hold: fire key pressed this frame and not pressed the previous frame (edge detect), shot cooldown counter == 0, bullet_active == 0, and state is ALIVE or RESPAWN.
REQ-011 On a fire pulse, the shot cooldown counter SHALL load COOLDOWN-1, then decrement once per frame, saturating at 0.
REQ-012 A fire key that is held SHALL NOT re-fire; a fresh press is required.
REQ-013 hit in ALIVE SHALL enter EXPLODE, decrement lives, and load the explosion counter with EXPLODE_FRAMES-1.
REQ-014 hit in RESPAWN, EXPLODE or GAME_OVER SHALL be ignored.
REQ-015 If hit and a fire condition occur in the same ALIVE frame, hit SHALL win and fire SHALL stay 0.
REQ-016 In EXPLODE, movement and fire SHALL be inhibited and the explosion counter SHALL decrement each frame.
REQ-017 At count 0 in EXPLODE: if lives == 0, go to GAME_OVER; otherwise go to RESPAWN, set ship_x=(SCREEN_W-SHIP_W)/2, and load the invulnerability counter with INVULN_FRAMES-1.
REQ-018 RESPAWN SHALL go to ALIVE when the invulnerability counter reaches 0.
REQ-019 visible SHALL be 1 in ALIVE, 0 in EXPLODE and GAME_OVER, and equal to bit 3 of the invulnerability counter in RESPAWN.
REQ-020 GAME_OVER SHALL be absorbing until Reset; all inputs are ignored there and fire=0.

Reset
REQ-021 Reset SHALL set: ship_x=(SCREEN_W-SHIP_W)/2 (307 at default), state=ALIVE, lives=START_LIVES, fire=0, visible=1, all counters=0, previous-fire-key register=0.
REQ-022 Reset asserted mid-EXPLODE or mid-RESPAWN SHALL return the block to the REQ-021 values immediately, with no pending fire pulse.

Verification
REQ-023 Hold left from reset for 200 frames -> ship_x decreases 307,305,...,1, then stays at 0 with no wrap.
REQ-024 Right on channel 0 with left on channel 1 -> ship_x stays 307; right alone -> ship_x saturates at 614.
REQ-025 Fire pressed at frame 5 and held 40 frames -> exactly one pulse; release, then press again at frame 20 after the first pulse -> no pulse (cooldown); press at frame 31 -> pulse; press while bullet_active=1 -> no pulse.
REQ-026 hit pulse -> state=1, lives=2, visible=0 for 60 frames; then state=2, ship_x=307, visible blinks; after 120 frames state=0; hit during RESPAWN -> no change.
REQ-027 Three hits, each in ALIVE -> lives=0, then after the third explosion state=3; keys and hit afterwards are ignored; Reset -> lives=3, state=0.
